// File: rtl/sdram_bus_pkg.sv
// Shared definitions for the kernel-bus to SDRAM-controller bridge.
package sdram_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        RREQ,
        DONE,
        HOLD
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // {UDQM, LDQM} while no transaction owns the bus: both lanes masked
    localparam logic [1:0] DQM_IDLE = 2'b11;

endpackage

// File: rtl/sdram_bus_bridge_watchdog.sv
// Outstanding-request watchdog: counts enabled cycles and flags the LIMIT-th one.
module bus_watchdog
    import sdram_bus_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] r_count;

    // Count enabled cycles, saturating at LIMIT so the counter never wraps
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != W'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is flagged during the LIMIT-th enabled cycle so the owner can leave on that edge
    assign o_expired = i_enable && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/sdram_bus_bridge.sv
// Registered bridge from the kernel memory bus to the SDRAM controller req/ack interface.
module sdram_bus_bridge
    import sdram_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CTL_ADDR_W     = 22
) (
    input  logic                  clk_p,
    input  logic                  sdram_reset,
    input  logic                  bus_stb,
    input  logic                  bus_we,
    input  logic [1:0]            bus_sel,
    input  logic [20:0]           bus_adr,
    input  logic [15:0]           bus_out,
    output logic [15:0]           bus_dat,
    output logic                  bus_ack,
    input  logic                  ctl_ready,
    output logic                  ctl_wr_req,
    output logic                  ctl_rd_req,
    input  logic                  ctl_wr_ack,
    input  logic                  ctl_rd_ack,
    output logic [CTL_ADDR_W-1:0] ctl_addr,
    output logic [15:0]           ctl_wdata,
    input  logic [15:0]           ctl_rdata,
    output logic [1:0]            ctl_be,
    output logic                  dram_h,
    output logic                  dram_l,
    output logic                  timeout_err
);

    state_t                r_state;
    state_t                w_next;
    logic [CTL_ADDR_W-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [1:0]            r_be;
    logic [1:0]            r_dqm;
    logic [15:0]           r_rdata;
    logic                  r_terr;
    logic                  w_in_req;
    logic                  w_accept;
    logic                  w_expired;
    logic                  w_timeout;

    assign w_in_req = (r_state == WREQ) || (r_state == RREQ);
    assign w_accept = (r_state == IDLE) && bus_stb && ctl_ready;

    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (clk_p),
        .i_rst    (sdram_reset),
        .i_clear  (!w_in_req),
        .i_enable (w_in_req),
        .o_expired(w_expired)
    );

    // Next-state decode; a matching ack takes priority over watchdog expiry
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = bus_we ? WREQ : RREQ;
                end
            end
            WREQ: begin
                if (ctl_wr_ack) begin
                    w_next = DONE;
                end else if (w_expired) begin
                    w_next    = HOLD;
                    w_timeout = 1'b1;
                end
            end
            RREQ: begin
                if (ctl_rd_ack) begin
                    w_next = DONE;
                end else if (w_expired) begin
                    w_next    = HOLD;
                    w_timeout = 1'b1;
                end
            end
            DONE, HOLD: begin
                if (!bus_stb) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, latched transaction fields, read data, DQM and sticky timeout flag
    always_ff @(posedge clk_p) begin
        if (sdram_reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_dqm   <= DQM_IDLE;
            r_rdata <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= CTL_ADDR_W'(bus_adr);
                r_wdata <= bus_out;
                r_be    <= bus_we ? bus_sel : 2'b11;
                r_dqm   <= bus_we ? ~bus_sel : 2'b00;
            end
            if ((r_state == RREQ) && ctl_rd_ack) begin
                r_rdata <= ctl_rdata;
            end
            if (((r_state == DONE) || (r_state == HOLD)) && !bus_stb) begin
                r_dqm <= DQM_IDLE;
            end
            if (w_timeout) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign ctl_wr_req  = (r_state == WREQ);
    assign ctl_rd_req  = (r_state == RREQ);
    assign bus_ack     = (r_state == DONE) && bus_stb;
    assign bus_dat     = r_rdata;
    assign ctl_addr    = r_addr;
    assign ctl_wdata   = r_wdata;
    assign ctl_be      = r_be;
    assign dram_h      = r_dqm[1];
    assign dram_l      = r_dqm[0];
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Scoreboard bench for sdram_bus_bridge with an 8-cycle watchdog.
module tb_sdram_bus_bridge;

    typedef struct {
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [1:0]  dqm;
        logic [15:0] rdata;
    } txn_t;

    logic        clk_p = 1'b0;
    logic        sdram_reset;
    logic        bus_stb;
    logic        bus_we;
    logic [1:0]  bus_sel;
    logic [20:0] bus_adr;
    logic [15:0] bus_out;
    logic [15:0] bus_dat;
    logic        bus_ack;
    logic        ctl_ready;
    logic        ctl_wr_req;
    logic        ctl_rd_req;
    logic        ctl_wr_ack;
    logic        ctl_rd_ack;
    logic [21:0] ctl_addr;
    logic [15:0] ctl_wdata;
    logic [15:0] ctl_rdata;
    logic [1:0]  ctl_be;
    logic        dram_h;
    logic        dram_l;
    logic        timeout_err;

    int   n_checks = 0;
    int   n_errors = 0;
    txn_t exp_q[$];

    sdram_bus_bridge #(
        .TIMEOUT_CYCLES(8),
        .CTL_ADDR_W    (22)
    ) dut (
        .clk_p      (clk_p),
        .sdram_reset(sdram_reset),
        .bus_stb    (bus_stb),
        .bus_we     (bus_we),
        .bus_sel    (bus_sel),
        .bus_adr    (bus_adr),
        .bus_out    (bus_out),
        .bus_dat    (bus_dat),
        .bus_ack    (bus_ack),
        .ctl_ready  (ctl_ready),
        .ctl_wr_req (ctl_wr_req),
        .ctl_rd_req (ctl_rd_req),
        .ctl_wr_ack (ctl_wr_ack),
        .ctl_rd_ack (ctl_rd_ack),
        .ctl_addr   (ctl_addr),
        .ctl_wdata  (ctl_wdata),
        .ctl_rdata  (ctl_rdata),
        .ctl_be     (ctl_be),
        .dram_h     (dram_h),
        .dram_l     (dram_l),
        .timeout_err(timeout_err)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_p);
        #1;
    endtask

    // Drive a bus transaction and record what the controller side must show
    task automatic drive_txn(input logic we, input logic [20:0] adr, input logic [1:0] sel,
                             input logic [15:0] wd, input logic [15:0] rd);
        txn_t t;
        bus_stb = 1'b1;
        bus_we  = we;
        bus_adr = adr;
        bus_sel = sel;
        bus_out = wd;
        t.addr  = {1'b0, adr};
        t.wdata = wd;
        t.be    = we ? sel : 2'b11;
        t.dqm   = we ? ~sel : 2'b00;
        t.rdata = rd;
        exp_q.push_back(t);
    endtask

    task automatic test_reset;
        sdram_reset = 1'b1;
        bus_stb = 0; bus_we = 0; bus_sel = 0; bus_adr = 0; bus_out = 0;
        ctl_ready = 0; ctl_wr_ack = 0; ctl_rd_ack = 0; ctl_rdata = 16'hFFFF;
        tick; tick;
        n_checks++;
        if ({ctl_wr_req, ctl_rd_req, bus_ack, timeout_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ctl_wr_req, ctl_rd_req, bus_ack, timeout_err});
        end
        n_checks++;
        if ({dram_h, dram_l} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_dqm: got %b expected 11", {dram_h, dram_l});
        end
        n_checks++;
        if ({bus_dat, ctl_addr, ctl_wdata, ctl_be} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: dat=%h addr=%h wdata=%h be=%b expected all 0", bus_dat, ctl_addr, ctl_wdata, ctl_be);
        end
        sdram_reset = 1'b0;
        ctl_ready = 1'b1;
        tick;
    endtask

    task automatic test_read;
        txn_t t;
        int   rq;
        drive_txn(1'b0, 21'h01_2345, 2'b01, 16'h1111, 16'hA5C3);
        tick;
        t = exp_q.pop_front();
        n_checks++;
        if ({ctl_wr_req, ctl_rd_req} !== 2'b01) begin
            n_errors++;
            $display("FAIL read_req: got wr/rd %b expected 01", {ctl_wr_req, ctl_rd_req});
        end
        n_checks++;
        if ({ctl_addr, ctl_wdata, ctl_be, dram_h, dram_l} !== {t.addr, t.wdata, t.be, t.dqm}) begin
            n_errors++;
            $display("FAIL read_fields: got addr=%h wd=%h be=%b dqm=%b expected addr=%h wd=%h be=%b dqm=%b",
                     ctl_addr, ctl_wdata, ctl_be, {dram_h, dram_l}, t.addr, t.wdata, t.be, t.dqm);
        end
        rq = 0;
        for (int i = 0; i < 3; i++) begin
            if (ctl_rd_req) rq++;
            if (i == 2) begin
                ctl_rd_ack = 1'b1;
                ctl_rdata  = 16'hA5C3;
            end
            tick;
        end
        ctl_rd_ack = 1'b0;
        ctl_rdata  = 16'h0000;
        n_checks++;
        if (rq != 3 || ctl_rd_req !== 1'b0) begin
            n_errors++;
            $display("FAIL read_req_len: got %0d cycles (req now %b) expected 3 then 0", rq, ctl_rd_req);
        end
        n_checks++;
        if (bus_ack !== 1'b1 || bus_dat !== t.rdata) begin
            n_errors++;
            $display("FAIL read_data: got ack=%b dat=%h expected ack=1 dat=%h", bus_ack, bus_dat, t.rdata);
        end
        tick;
        n_checks++;
        if (bus_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL read_ack_hold: got %b expected 1", bus_ack);
        end
        bus_stb = 1'b0;
        #1;
        n_checks++;
        if (bus_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL read_ack_drop: got %b expected 0", bus_ack);
        end
        tick;
        n_checks++;
        if ({dram_h, dram_l} !== 2'b11) begin
            n_errors++;
            $display("FAIL read_idle_dqm: got %b expected 11", {dram_h, dram_l});
        end
    endtask

    task automatic test_write_high;
        txn_t t;
        drive_txn(1'b1, 21'h1F_FFFF, 2'b10, 16'hBEEF, 16'h0000);
        tick;
        t = exp_q.pop_front();
        n_checks++;
        if ({ctl_wr_req, ctl_rd_req} !== 2'b10) begin
            n_errors++;
            $display("FAIL write_req: got wr/rd %b expected 10", {ctl_wr_req, ctl_rd_req});
        end
        n_checks++;
        if ({ctl_addr, ctl_wdata, ctl_be, dram_h, dram_l} !== {t.addr, t.wdata, t.be, t.dqm}) begin
            n_errors++;
            $display("FAIL write_fields: got addr=%h wd=%h be=%b dqm=%b expected addr=%h wd=%h be=%b dqm=%b",
                     ctl_addr, ctl_wdata, ctl_be, {dram_h, dram_l}, t.addr, t.wdata, t.be, t.dqm);
        end
        // wrong-direction ack and bus changes mid-request must not disturb anything
        ctl_rd_ack = 1'b1;
        bus_adr = 21'h00_0001; bus_out = 16'h0000; bus_sel = 2'b01; bus_we = 1'b0;
        tick;
        ctl_rd_ack = 1'b0;
        n_checks++;
        if (ctl_wr_req !== 1'b1 || bus_ack !== 1'b0 || {ctl_addr, ctl_wdata, ctl_be} !== {t.addr, t.wdata, t.be}) begin
            n_errors++;
            $display("FAIL write_hold: got req=%b ack=%b addr=%h wd=%h be=%b expected req=1 ack=0 addr=%h wd=%h be=%b",
                     ctl_wr_req, bus_ack, ctl_addr, ctl_wdata, ctl_be, t.addr, t.wdata, t.be);
        end
        ctl_wr_ack = 1'b1;
        tick;
        ctl_wr_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b1 || ctl_wr_req !== 1'b0) begin
            n_errors++;
            $display("FAIL write_ack: got ack=%b req=%b expected ack=1 req=0", bus_ack, ctl_wr_req);
        end
        bus_stb = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        txn_t t;
        drive_txn(1'b1, 21'h00_0010, 2'b11, 16'h1357, 16'h0000);
        tick;
        t = exp_q.pop_front();
        ctl_wr_ack = 1'b1;
        tick;
        ctl_wr_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_min_latency: got ack=%b expected 1 two edges after stb", bus_ack);
        end
        bus_stb = 1'b0;
        tick;
        drive_txn(1'b0, 21'h00_0020, 2'b00, 16'h2468, 16'h9ABC);
        tick;
        t = exp_q.pop_front();
        n_checks++;
        if (ctl_rd_req !== 1'b1 || {ctl_addr, ctl_wdata, ctl_be, dram_h, dram_l} !== {t.addr, t.wdata, t.be, t.dqm}) begin
            n_errors++;
            $display("FAIL b2b_second: got req=%b addr=%h wd=%h be=%b dqm=%b expected req=1 addr=%h wd=%h be=%b dqm=%b",
                     ctl_rd_req, ctl_addr, ctl_wdata, ctl_be, {dram_h, dram_l}, t.addr, t.wdata, t.be, t.dqm);
        end
        ctl_rd_ack = 1'b1;
        ctl_rdata  = 16'h9ABC;
        tick;
        ctl_rd_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b1 || bus_dat !== t.rdata) begin
            n_errors++;
            $display("FAIL b2b_read: got ack=%b dat=%h expected ack=1 dat=%h", bus_ack, bus_dat, t.rdata);
        end
        bus_stb = 1'b0;
        tick;
    endtask

    task automatic test_not_ready;
        txn_t t;
        int   seen;
        ctl_ready = 1'b0;
        drive_txn(1'b0, 21'h0A_BCDE, 2'b11, 16'h0000, 16'h7777);
        seen = 0;
        repeat (10) begin
            tick;
            if (ctl_rd_req || ctl_wr_req) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL notready_noreq: got %0d request cycles expected 0", seen);
        end
        ctl_ready = 1'b1;
        tick;
        t = exp_q.pop_front();
        n_checks++;
        if (ctl_rd_req !== 1'b1 || ctl_addr !== t.addr) begin
            n_errors++;
            $display("FAIL notready_req: got req=%b addr=%h expected req=1 addr=%h", ctl_rd_req, ctl_addr, t.addr);
        end
        ctl_rd_ack = 1'b1;
        ctl_rdata  = 16'h7777;
        tick;
        ctl_rd_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b1 || bus_dat !== t.rdata) begin
            n_errors++;
            $display("FAIL notready_data: got ack=%b dat=%h expected ack=1 dat=%h", bus_ack, bus_dat, t.rdata);
        end
        bus_stb = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        txn_t t;
        int   held;
        int   acks;
        drive_txn(1'b0, 21'h05_5555, 2'b11, 16'h0000, 16'h0F0F);
        tick;
        t = exp_q.pop_front();
        bus_stb = 1'b0;
        held = 0;
        acks = 0;
        repeat (4) begin
            tick;
            if (ctl_rd_req) held++;
            if (bus_ack) acks++;
        end
        n_checks++;
        if (held != 4) begin
            n_errors++;
            $display("FAIL abort_held: got %0d held cycles expected 4", held);
        end
        ctl_rd_ack = 1'b1;
        ctl_rdata  = t.rdata;
        tick;
        ctl_rd_ack = 1'b0;
        if (bus_ack) acks++;
        n_checks++;
        if (ctl_rd_req !== 1'b0 || {dram_h, dram_l} !== 2'b00) begin
            n_errors++;
            $display("FAIL abort_done: got req=%b dqm=%b expected req=0 dqm=00", ctl_rd_req, {dram_h, dram_l});
        end
        tick;
        if (bus_ack) acks++;
        n_checks++;
        if ({dram_h, dram_l} !== 2'b11 || acks != 0) begin
            n_errors++;
            $display("FAIL abort_idle: got dqm=%b acks=%0d expected dqm=11 acks=0", {dram_h, dram_l}, acks);
        end
    endtask

    task automatic test_ack_at_expiry;
        int rq;
        drive_txn(1'b1, 21'h00_0100, 2'b01, 16'hCAFE, 16'h0000);
        tick;
        void'(exp_q.pop_front());
        rq = 0;
        for (int i = 0; i < 8; i++) begin
            if (ctl_wr_req) rq++;
            if (i == 7) ctl_wr_ack = 1'b1;
            tick;
        end
        ctl_wr_ack = 1'b0;
        n_checks++;
        if (rq != 8 || bus_ack !== 1'b1 || timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_at_expiry: got req_cycles=%0d ack=%b terr=%b expected 8 1 0", rq, bus_ack, timeout_err);
        end
        bus_stb = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        txn_t t;
        int   n;
        drive_txn(1'b0, 21'h03_0303, 2'b11, 16'h0000, 16'h0000);
        tick;
        void'(exp_q.pop_front());
        n = 0;
        while (ctl_rd_req && n < 20) begin
            n++;
            tick;
        end
        n_checks++;
        if (n != 8 || timeout_err !== 1'b1 || bus_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_expire: got req_cycles=%0d terr=%b ack=%b expected 8 1 0", n, timeout_err, bus_ack);
        end
        ctl_rd_ack = 1'b1;
        tick;
        ctl_rd_ack = 1'b0;
        tick;
        n_checks++;
        if (bus_ack !== 1'b0 || ctl_rd_req !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_hold: got ack=%b req=%b expected 0 0", bus_ack, ctl_rd_req);
        end
        bus_stb = 1'b0;
        tick;
        n_checks++;
        if ({dram_h, dram_l} !== 2'b11) begin
            n_errors++;
            $display("FAIL timeout_idle: got dqm=%b expected 11", {dram_h, dram_l});
        end
        drive_txn(1'b1, 21'h00_0042, 2'b01, 16'h1234, 16'h0000);
        tick;
        t = exp_q.pop_front();
        n_checks++;
        if (ctl_wr_req !== 1'b1 || {ctl_addr, ctl_wdata, ctl_be, dram_h, dram_l} !== {t.addr, t.wdata, t.be, t.dqm}) begin
            n_errors++;
            $display("FAIL timeout_retry_fields: got req=%b addr=%h wd=%h be=%b dqm=%b expected req=1 addr=%h wd=%h be=%b dqm=%b",
                     ctl_wr_req, ctl_addr, ctl_wdata, ctl_be, {dram_h, dram_l}, t.addr, t.wdata, t.be, t.dqm);
        end
        ctl_wr_ack = 1'b1;
        tick;
        ctl_wr_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b1 || timeout_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_retry: got ack=%b terr=%b expected 1 1", bus_ack, timeout_err);
        end
        bus_stb = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        drive_txn(1'b1, 21'h00_0777, 2'b10, 16'h5A5A, 16'h0000);
        tick;
        void'(exp_q.pop_front());
        sdram_reset = 1'b1;
        tick;
        sdram_reset = 1'b0;
        bus_stb     = 1'b0;
        ctl_wr_ack  = 1'b1;
        n_checks++;
        if (ctl_wr_req !== 1'b0 || {dram_h, dram_l} !== 2'b11 || timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got req=%b dqm=%b terr=%b expected 0 11 0", ctl_wr_req, {dram_h, dram_l}, timeout_err);
        end
        tick;
        ctl_wr_ack = 1'b0;
        n_checks++;
        if (bus_ack !== 1'b0 || ctl_wr_req !== 1'b0 || {dram_h, dram_l} !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_mid_ack: got ack=%b req=%b dqm=%b expected 0 0 11", bus_ack, ctl_wr_req, {dram_h, dram_l});
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_high;
        test_back_to_back;
        test_not_ready;
        test_abort;
        test_ack_at_expiry;
        test_timeout;
        test_reset_mid;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_bus_bridge.md
Name: sdram_bus_bridge

Overview:
Registered bridge between the kernel memory bus (stb/we/sel/adr/out/dat/ack) and the SDRAM controller's req/ack interface. The board top gates it with the DRAM-region strobe, above the low 128 KB that is served by on-chip RAM. It latches address, write data and byte lanes at transaction start and drives a held request until the controller acknowledges. It captures read data, returns a level ack to the kernel, and drives DQM synchronously. This replaces the strobe-edge DQM latch with clk_p-domain logic.

Parameters:
TIMEOUT_CYCLES, 255, cycles a request may stay outstanding before abandon (1..65535)
CTL_ADDR_W, 22, controller address width; upper bits zero-extended above bus adr[21:1]

Ports:
clk_p  in  1  bus/controller clock; all logic on rising edge
sdram_reset  in  1  synchronous active-high reset
bus_stb  in  1  transaction strobe (DRAM region already decoded)
bus_we  in  1  1=write, 0=read
bus_sel  in  2  byte lanes [1]=high, [0]=low
bus_adr  in  21  word address adr[21:1]
bus_out  in  16  write data from kernel
bus_dat  out  16  read data to kernel
bus_ack  out  1  transaction acknowledge
ctl_ready  in  1  controller init done
ctl_wr_req  out  1  write request, held until ctl_wr_ack
ctl_rd_req  out  1  read request, held until ctl_rd_ack
ctl_wr_ack  in  1  write complete pulse
ctl_rd_ack  in  1  read complete pulse; ctl_rdata valid same cycle
ctl_addr  out  CTL_ADDR_W  latched address
ctl_wdata  out  16  latched write data
ctl_rdata  in  16  controller read data
ctl_be  out  2  latched byte enables (2'b11 on reads)
dram_h  out  1  UDQM, active-high mask
dram_l  out  1  LDQM, active-high mask
timeout_err  out  1  sticky: a request timed out

Behaviour:
- One clock domain, clk_p. Reset is synchronous and active-high via sdram_reset.
- Reset state: IDLE. All outputs 0, except dram_h=dram_l=1, which masks the bus while idle. bus_dat=0, timeout_err=0, watchdog=0. Reset mid-transaction drops requests at the same edge. The controller's pending ack is then ignored.
- FSM states: IDLE, WREQ, RREQ, DONE, HOLD.
- IDLE: when bus_stb & ctl_ready, latch adr/out/sel/we.
  - ctl_addr={0,bus_adr}.
  - Write: ctl_be=sel, dram_h=~sel[1], dram_l=~sel[0], next state WREQ.
  - Read: ctl_be=11, dram_h=dram_l=0, next state RREQ.
  - ctl_ready=0 keeps the FSM in IDLE with no request.
- ctl_wr_req = (state==WREQ), ctl_rd_req = (state==RREQ). Both are registered-state decodes and are never asserted together.
- WREQ: ctl_wr_ack goes to DONE. ctl_rd_ack is ignored.
- RREQ: ctl_rd_ack captures bus_dat<=ctl_rdata and goes to DONE. ctl_wr_ack is ignored.
- Latency: stb is sampled at edge N, so the request is high after N. The ack is sampled at edge M, so bus_ack is high after M. Minimum is 2 cycles from stb to ack, given a same-cycle controller ack.
- DONE: bus_ack = (state==DONE) & bus_stb, combinational on the registered state.
  - Stay in DONE while bus_stb=1.
  - Go to IDLE on the first cycle bus_stb=0; dram_h/dram_l return to 1.
  - A new stb is accepted in IDLE the cycle after, so back-to-back accesses have 1 dead cycle.
- Master abort: if bus_stb drops during WREQ/RREQ, the request stays held because SDRAM cannot be aborted. On ack, go to DONE, which exits immediately. No bus_ack is seen because stb=0.
- Watchdog: resets on entry to WREQ/RREQ and increments each cycle there. When it reaches TIMEOUT_CYCLES with no matching ack:
  - Drop the request.
  - Set timeout_err (sticky until reset).
  - Go to HOLD.
- HOLD: no bus_ack, leaving the kernel's bus-timeout trap to act. Go to IDLE when bus_stb=0.
- An ack arriving in the same cycle the watchdog expires wins: the FSM goes to DONE and timeout_err is not set.
- Acks arriving in IDLE, DONE or HOLD are ignored.
- Latched fields hold stable from request assertion to ack. Bus inputs changing mid-transaction have no effect.
- The watchdog is sized $clog2(TIMEOUT_CYCLES+1) bits and never wraps. It saturates at expiry.

Decomposition:
- Shared package sdram_bus_pkg holds the FSM state enum {IDLE,WREQ,RREQ,DONE,HOLD}, a default-timeout constant, and the DQM idle value (2'b11).
- One sub-module, bus_watchdog: clear/enable inputs, expired output, parameter LIMIT. It is reusable by the on-chip RAM path.

Test Plan:
- Read: ctl_ready=1, stb, we=0, adr=21'h01_2345; ctl_rd_ack 3 cycles after the request with rdata=16'hA5C3. Required response:
  - ctl_rd_req high for exactly 3 cycles.
  - ctl_addr=22'h01_2345, ctl_be=11, dram_h=dram_l=0.
  - bus_dat=A5C3 and bus_ack high until stb drops.
- High-byte write: we=1, sel=10, out=16'hBEEF. Required response: ctl_wr_req high, ctl_wdata=BEEF, ctl_be=10, dram_h=0, dram_l=1; bus_ack follows ctl_wr_ack by 1 cycle.
- ctl_ready=0 with stb held for 10 cycles, then ctl_ready=1. Required response: no request for 10 cycles; request asserted 1 cycle after ready rises.
- Abort: stb drops 1 cycle into RREQ; rd_ack arrives 4 cycles later. Required response: request held until the ack, bus_ack never high, FSM back in IDLE 2 cycles after the ack.
- Timeout with TIMEOUT_CYCLES=8 and no ack. Required response:
  - Request drops after 8 cycles and timeout_err=1.
  - bus_ack stays 0; IDLE after stb drops.
  - A second, acked transaction succeeds with timeout_err still 1.
- sdram_reset asserted for 1 cycle mid-WREQ, with ctl_wr_ack pulsed 1 cycle later. Required response: ctl_wr_req=0 and dram_h=dram_l=1 the next cycle, the ack is ignored, and bus_ack stays 0.
